// File: rtl/router_axis_pkg.sv
// Shared types and helpers for the router AXI-Stream blocks.
//   AXIS_DATA_W / AXIS_KEEP_W : egress beat geometry (32-bit data, 4 byte enables)
//   axis_beat_t               : one beat as carried through register slices
//   arb_state_t               : egress arbiter FSM encoding
//   clogb2()                  : ceil(log2(n)), never less than 1 (safe as a port width)
package router_axis_pkg;

  localparam int AXIS_DATA_W = 32;
  localparam int AXIS_KEEP_W = 4;

  typedef struct packed {
    logic                   last;
    logic [AXIS_KEEP_W-1:0] keep;
    logic [AXIS_DATA_W-1:0] data;
  } axis_beat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  function automatic int clogb2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Two-entry AXI-Stream skid buffer.
//   axis_clk, axis_reset : clock, synchronous active-high reset
//   s_axis_*             : upstream beat (tdata/tkeep/tlast/tvalid in, tready out)
//   m_axis_*             : downstream beat (tdata/tkeep/tlast/tvalid out, tready in)
// Sustains one beat per cycle. s_axis_tready comes straight from a flop, so there
// is no combinational path from m_axis_tready back upstream.
module axis_reg_slice
  import router_axis_pkg::*;
(
  input  logic                   axis_clk,
  input  logic                   axis_reset,
  input  logic [AXIS_DATA_W-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_W-1:0] s_axis_tkeep,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  output logic                   s_axis_tready,
  output logic [AXIS_DATA_W-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_W-1:0] m_axis_tkeep,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready
);

  axis_beat_t out_q, skid_q, s_beat;
  logic       out_vld, skid_vld;
  logic       s_fire, out_free;

  assign s_beat        = '{last: s_axis_tlast, keep: s_axis_tkeep, data: s_axis_tdata};
  assign s_axis_tready = !skid_vld;
  assign s_fire        = s_axis_tvalid && !skid_vld;
  // Output register can take a new beat this cycle.
  assign out_free      = !out_vld || m_axis_tready;

  always_ff @(posedge axis_clk) begin
    if (axis_reset) begin
      out_q    <= '0;
      skid_q   <= '0;
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
    end else if (out_free) begin
      if (skid_vld) begin
        // Upstream was stalled while skid was full, so no new beat competes here.
        out_q    <= skid_q;
        out_vld  <= 1'b1;
        skid_vld <= 1'b0;
      end else begin
        out_vld <= s_fire;
        if (s_fire) out_q <= s_beat;
      end
    end else if (s_fire) begin
      // Output is stalled: park the beat that was accepted under the registered ready.
      skid_q   <= s_beat;
      skid_vld <= 1'b1;
    end
  end

  assign m_axis_tdata  = out_q.data;
  assign m_axis_tkeep  = out_q.keep;
  assign m_axis_tlast  = out_q.last;
  assign m_axis_tvalid = out_vld;

endmodule

// File: rtl/axis_egress_arbiter.sv
// Packet-granular round-robin arbiter sharing one egress AXI-Stream port.
//   axis_clk, axis_reset : clock, synchronous active-high reset
//   s_axis_*             : NUM_PORTS packed input streams (port i at [32i+31:32i] etc.)
//   m_axis_*             : egress stream, driven from a two-entry skid buffer
//   pause                : blocks new grants; a packet in flight still completes
//   grant_port           : current / last granted port
//   busy                 : high while a packet is being moved or drained
//   pkt_count            : completed packets per port (port i at [CNT_WIDTH*i +: CNT_WIDTH])
//   trunc_count          : packets cut by the length watchdog, all ports
// A granted port keeps the grant until its tlast. A packet reaching MAX_PKT_WORDS
// beats without tlast is closed early on egress and the rest is swallowed.
module axis_egress_arbiter
  import router_axis_pkg::*;
#(
  parameter  int NUM_PORTS     = 4,
  parameter  int MAX_PKT_WORDS = 512,
  parameter  int CNT_WIDTH     = 32,
  localparam int GW            = clogb2(NUM_PORTS),
  localparam int WCW           = clogb2(MAX_PKT_WORDS) + 1
) (
  input  logic                             axis_clk,
  input  logic                             axis_reset,
  input  logic [NUM_PORTS*AXIS_DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_PORTS*AXIS_KEEP_W-1:0] s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]             s_axis_tlast,
  output logic [NUM_PORTS-1:0]             s_axis_tready,
  output logic [AXIS_DATA_W-1:0]           m_axis_tdata,
  output logic [AXIS_KEEP_W-1:0]           m_axis_tkeep,
  output logic                             m_axis_tvalid,
  output logic                             m_axis_tlast,
  input  logic                             m_axis_tready,
  input  logic                             pause,
  output logic [GW-1:0]                    grant_port,
  output logic                             busy,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]   pkt_count,
  output logic [CNT_WIDTH-1:0]             trunc_count
);

  logic [NUM_PORTS-1:0][AXIS_DATA_W-1:0] in_data;
  logic [NUM_PORTS-1:0][AXIS_KEEP_W-1:0] in_keep;

  arb_state_t     state, state_nxt;
  logic [GW-1:0]  last_grant, sel_port, cand;
  logic           sel_vld, grant_now;
  logic [WCW-1:0] word_cnt;
  logic [CNT_WIDTH-1:0] trunc_q;

  logic g_vld, g_last, wd_hit, xfer_acc, drain_acc, pkt_done;
  logic sl_valid, sl_ready;

  assign in_data = s_axis_tdata;
  assign in_keep = s_axis_tkeep;

  // Rotating priority: first requester after last_grant, wrapping.
  always_comb begin
    sel_vld  = 1'b0;
    sel_port = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = GW'((int'(last_grant) + k) % NUM_PORTS);
      if (!sel_vld && s_axis_tvalid[cand]) begin
        sel_vld  = 1'b1;
        sel_port = cand;
      end
    end
  end

  assign grant_now = (state == IDLE) && !pause && sel_vld;

  assign g_vld     = s_axis_tvalid[grant_port];
  assign g_last    = s_axis_tlast[grant_port];
  // Beat being accepted now is the MAX_PKT_WORDS-th of the packet.
  assign wd_hit    = (word_cnt == WCW'(MAX_PKT_WORDS - 1));
  assign xfer_acc  = (state == XFER) && g_vld && sl_ready;
  assign drain_acc = (state == DRAIN) && g_vld;
  assign pkt_done  = xfer_acc && g_last;
  assign sl_valid  = (state == XFER) && g_vld;

  // FSM: state register
  always_ff @(posedge axis_clk) begin
    if (axis_reset) state <= IDLE;
    else            state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant_now) state_nxt = XFER;
      XFER:    if (xfer_acc) begin
                 if (g_last)      state_nxt = IDLE;
                 else if (wd_hit) state_nxt = DRAIN;
               end
      DRAIN:   if (drain_acc && g_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    s_axis_tready = '0;
    busy          = (state != IDLE);
    unique case (state)
      XFER:    s_axis_tready[grant_port] = sl_ready;
      DRAIN:   s_axis_tready[grant_port] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_reset) begin
      grant_port <= '0;
      last_grant <= GW'(NUM_PORTS - 1);
      word_cnt   <= '0;
      trunc_q    <= '0;
    end else begin
      if (grant_now) begin
        grant_port <= sel_port;
        word_cnt   <= '0;
      end
      if (xfer_acc) begin
        word_cnt <= word_cnt + WCW'(1);
        if (g_last || wd_hit)  last_grant <= grant_port;
        if (!g_last && wd_hit) trunc_q    <= trunc_q + CNT_WIDTH'(1);
      end
    end
  end

  assign trunc_count = trunc_q;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_pkt_cnt
    logic [CNT_WIDTH-1:0] cnt_q;
    always_ff @(posedge axis_clk) begin
      if (axis_reset)                                cnt_q <= '0;
      else if (pkt_done && grant_port == GW'(i))     cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
    assign pkt_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end

  // Truncated beat keeps its tkeep; only tlast is forced.
  axis_reg_slice u_slice (
    .axis_clk      (axis_clk),
    .axis_reset    (axis_reset),
    .s_axis_tdata  (in_data[grant_port]),
    .s_axis_tkeep  (in_keep[grant_port]),
    .s_axis_tvalid (sl_valid),
    .s_axis_tlast  (g_last | wd_hit),
    .s_axis_tready (sl_ready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

endmodule
